mc_datapath: RTL and testbench
==============================

// Module: mc_datapath
// PURPOSE
//  Multicycle RV32I-subset core: unified datapath plus control FSM sharing one memory port with a ready handshake.
//  Next generation of the single-cycle datapath: one ALU and one memory port are reused across states, with stall-tolerant memory.
//  Sits between the top level and a single instruction/data memory (or bus bridge).
// PARAMETERS
//  XLEN      32      datapath/register/address width
//  RESET_PC  32'h0   PC value loaded on reset
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     synchronous, active-high
//  MemReq     out  1     memory access request, valid for the whole wait
//  MemWE      out  1     1=write, 0=read; meaningful only with MemReq
//  MemAdr     out  XLEN  byte address (PC in fetch, ALUOut in load/store)
//  MemWData   out  XLEN  store data (register B)
//  MemRData   in   XLEN  read data, sampled on the cycle MemReady=1
//  MemReady   in   1     access completes on this cycle
//  Illegal    out  1     sticky flag: unsupported opcode decoded
// BEHAVIOUR
//  - Subset: lw, sw, add/sub/and/or/slt, addi/andi/ori/slti, beq, jal. ALUControl: 000 add, 001 sub, 010 and, 011 or, 101 slt. ImmSrc: 00 I, 01 S, 10 B, 11 J.
//  - Reset (clk edge with reset=1): state<=FETCH, PC<=RESET_PC, Illegal<=0. MemReq and MemWE are forced 0 while reset=1. Register file is not cleared.
//  - FETCH: MemReq=1, MemAdr=PC. Stay until MemReady. On ready: Instr<=MemRData, OldPC<=PC, PC<=PC+4, go to DECODE.
//  - DECODE: A<=rs1, B<=rs2, ALUOut<=OldPC+ImmB. Next state by opcode:
//    0000011 -> MEMADR, 0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL, any other -> TRAP.
//  - MEMADR: ALUOut<=A+Imm (I for lw, S for sw). Go to MEMREAD (lw) or MEMWRITE (sw).
//  - MEMREAD: MemReq=1, MemWE=0, MemAdr=ALUOut. Wait for MemReady, then Data<=MemRData and go to MEMWB.
//  - MEMWB: rd<=Data, then FETCH.
//  - MEMWRITE: MemReq=1, MemWE=1, MemWData=B. Wait for MemReady, then FETCH.
//  - EXECR: ALUOut<=A op B, decoded from funct3/funct7[5]; then ALUWB.
//  - EXECI: ALUOut<=A op ImmI; funct7[5] is ignored, so no subi; then ALUWB.
//  - ALUWB: rd<=ALUOut, then FETCH.
//  - BEQ: compute A-B. If Zero, PC<=ALUOut (the target computed in DECODE). Then FETCH.
//  - JAL: PC<=OldPC+ImmJ, rd<=OldPC+4, then FETCH.
//  - TRAP: Illegal<=1. Terminal state; the only exit is reset. MemReq=0.
//  - Writes to x0 are discarded, and x0 always reads 0.
//  - CPI: ALU=4, beq=3, jal=3, sw=4, lw=5, plus memory wait cycles.
//  - MemReady low: stall indefinitely. MemReq/MemWE/MemAdr/MemWData are held stable and no architectural state changes.
//  - MemReady while MemReq=0 is ignored.
//  - Reset during a wait: the access is abandoned, with MemReq=0 on the reset cycle. Fetch restarts at RESET_PC.
//  - Address low bits are not checked. Misaligned accesses pass through unmodified.
//  - PC arithmetic wraps modulo 2^XLEN.
// CONFIGURATION
//  - MC_PERF_CNT_EN defined: adds CycleCnt (out, XLEN) and InstrRetCnt (out, XLEN).
//    CycleCnt increments every non-reset cycle. InstrRetCnt increments on each transition into FETCH from a completing state.
//    Both are 0 on reset, wrap modulo 2^XLEN, and stop incrementing in TRAP.
//  - MC_PERF_CNT_EN undefined: ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared header riscv_defs.vh: opcode localparams, ALUControl codes, ImmSrc codes, FSM state encoding (4 bits).
//  - Sub-module mc_controller: the FSM plus ALU decoder, producing all muxes/enables.
//  - Datapath reuses the existing flopr, adder, regfile, extend, mux2, mux3 and alu blocks, plus enable-registers for PC, Instr, OldPC, A, B, ALUOut and Data.
// TESTING
//  1. Reset with RESET_PC=32'h100 -> first MemReq=1 with MemAdr=32'h100, MemWE=0; Illegal=0.
//  2. addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sw x3,8(x0) -> MemWE=1, MemAdr=8, MemWData=12. Instruction issue is 4 cycles apart with zero-wait memory.
//  3. lw x4,8(x0), with MemReady held low 3 cycles -> request signals stay stable; x4=12; lw takes 8 cycles total.
//  4. beq x1,x1,+16 at PC=0x20 -> next fetch at 0x30. beq x1,x2 not taken -> next fetch at 0x24.
//  5. jal x5,-8 at PC=0x40 -> x5=0x44, next fetch at 0x38. add x0,x1,x2 -> x0 reads 0.
//  6. Fetch opcode 7'h7F -> Illegal=1, MemReq=0 for good. Reset mid-MEMREAD -> fetch restarts at RESET_PC.
//     With MC_PERF_CNT_EN: counters return to 0 on reset and InstrRetCnt=4 after the scenario-2 program.

Source files
------------

// File: rtl/mc_datapath_pkg.sv
// Shared opcodes, ALU/immediate codes, FSM state encoding and the control bundle for the
// multicycle RV32I-subset core.
package mc_datapath_pkg;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StExecI    = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBeq      = 4'd9;
  localparam logic [3:0] StJal      = 4'd10;
  localparam logic [3:0] StTrap     = 4'd11;

  typedef enum logic [1:0] {SrcAPc, SrcAOldPc, SrcARegA} src_a_e;
  typedef enum logic [1:0] {SrcBRegB, SrcBImm, SrcBFour} src_b_e;
  typedef enum logic [1:0] {ResAluOut, ResData, ResPc} result_e;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;    // 0: PC, 1: ALUOut
    logic        ir_we;      // Instr and OldPC
    logic        pc_we;
    logic        pc_src;     // 0: ALU result, 1: ALUOut
    logic        ab_we;
    logic        aluout_we;
    logic        data_we;
    logic        reg_we;
    src_a_e      src_a;
    src_b_e      src_b;
    logic [1:0]  imm_src;
    logic [2:0]  alu_ctrl;
    result_e     result_src;
  } ctrl_t;

  localparam ctrl_t CtrlIdle = '{
    mem_req: 1'b0, mem_we: 1'b0, adr_src: 1'b0, ir_we: 1'b0, pc_we: 1'b0, pc_src: 1'b0,
    ab_we: 1'b0, aluout_we: 1'b0, data_we: 1'b0, reg_we: 1'b0,
    src_a: SrcAPc, src_b: SrcBRegB, imm_src: ImmI, alu_ctrl: AluAdd, result_src: ResAluOut
  };

  // funct7[5] only selects sub for register-register ops.
  function automatic logic [2:0] alu_decode(logic [2:0] funct3, logic funct7b5, logic is_r);
    case (funct3)
      3'b000:  alu_decode = (is_r && funct7b5) ? AluSub : AluAdd;
      3'b010:  alu_decode = AluSlt;
      3'b110:  alu_decode = AluOr;
      3'b111:  alu_decode = AluAnd;
      default: alu_decode = AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// Shared instruction/data memory port with a ready handshake.
interface mc_datapath_if #(
  parameter int unsigned XLEN = 32
);
  logic            MemReq;
  logic            MemWE;
  logic [XLEN-1:0] MemAdr;
  logic [XLEN-1:0] MemWData;
  logic [XLEN-1:0] MemRData;
  logic            MemReady;

  modport master (
    output MemReq, MemWE, MemAdr, MemWData,
    input  MemRData, MemReady
  );

  modport slave (
    input  MemReq, MemWE, MemAdr, MemWData,
    output MemRData, MemReady
  );
endinterface

// File: rtl/mc_controller.sv
// Control FSM and ALU decoder for the multicycle core. MC_PERF_CNT_EN adds retire/trap status
// outputs used by the performance counters.
module mc_controller
  import mc_datapath_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic       o_retire,
  output logic       o_trap
`endif
);

  logic [3:0] r_state;
  logic [3:0] w_state_next;
  logic       r_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StFetch;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StTrap) r_illegal <= 1'b1;
    end
  end

  assign o_illegal = r_illegal;

  always_comb begin
    o_ctrl       = CtrlIdle;
    w_state_next = r_state;
    case (r_state)
      StFetch: begin
        o_ctrl.mem_req  = 1'b1;
        o_ctrl.src_a    = SrcAPc;
        o_ctrl.src_b    = SrcBFour;
        if (i_mem_ready) begin
          o_ctrl.ir_we = 1'b1;
          o_ctrl.pc_we = 1'b1;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        // Branch target is computed speculatively while the register operands load.
        o_ctrl.ab_we     = 1'b1;
        o_ctrl.src_a     = SrcAOldPc;
        o_ctrl.src_b     = SrcBImm;
        o_ctrl.imm_src   = ImmB;
        o_ctrl.aluout_we = 1'b1;
        case (i_op)
          OpLoad, OpStore: w_state_next = StMemAdr;
          OpRType:         w_state_next = StExecR;
          OpIType:         w_state_next = StExecI;
          OpBeq:           w_state_next = StBeq;
          OpJal:           w_state_next = StJal;
          default:         w_state_next = StTrap;
        endcase
      end
      StMemAdr: begin
        o_ctrl.src_a     = SrcARegA;
        o_ctrl.src_b     = SrcBImm;
        o_ctrl.imm_src   = (i_op == OpStore) ? ImmS : ImmI;
        o_ctrl.aluout_we = 1'b1;
        w_state_next     = (i_op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.adr_src = 1'b1;
        if (i_mem_ready) begin
          o_ctrl.data_we = 1'b1;
          w_state_next   = StMemWb;
        end
      end
      StMemWb: begin
        o_ctrl.reg_we     = 1'b1;
        o_ctrl.result_src = ResData;
        w_state_next      = StFetch;
      end
      StMemWrite: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.mem_we  = 1'b1;
        o_ctrl.adr_src = 1'b1;
        if (i_mem_ready) w_state_next = StFetch;
      end
      StExecR: begin
        o_ctrl.src_a     = SrcARegA;
        o_ctrl.src_b     = SrcBRegB;
        o_ctrl.alu_ctrl  = alu_decode(i_funct3, i_funct7b5, 1'b1);
        o_ctrl.aluout_we = 1'b1;
        w_state_next     = StAluWb;
      end
      StExecI: begin
        o_ctrl.src_a     = SrcARegA;
        o_ctrl.src_b     = SrcBImm;
        o_ctrl.imm_src   = ImmI;
        o_ctrl.alu_ctrl  = alu_decode(i_funct3, i_funct7b5, 1'b0);
        o_ctrl.aluout_we = 1'b1;
        w_state_next     = StAluWb;
      end
      StAluWb: begin
        o_ctrl.reg_we     = 1'b1;
        o_ctrl.result_src = ResAluOut;
        w_state_next      = StFetch;
      end
      StBeq: begin
        o_ctrl.src_a    = SrcARegA;
        o_ctrl.src_b    = SrcBRegB;
        o_ctrl.alu_ctrl = AluSub;
        o_ctrl.pc_src   = 1'b1;
        o_ctrl.pc_we    = i_zero;
        w_state_next    = StFetch;
      end
      StJal: begin
        // PC already holds OldPC+4, so it doubles as the link value.
        o_ctrl.src_a      = SrcAOldPc;
        o_ctrl.src_b      = SrcBImm;
        o_ctrl.imm_src    = ImmJ;
        o_ctrl.pc_we      = 1'b1;
        o_ctrl.reg_we     = 1'b1;
        o_ctrl.result_src = ResPc;
        w_state_next      = StFetch;
      end
      StTrap:  w_state_next = StTrap;
      default: w_state_next = StFetch;
    endcase
    if (reset) o_ctrl = CtrlIdle;
  end

`ifdef MC_PERF_CNT_EN
  assign o_retire = !reset && (r_state != StFetch) && (w_state_next == StFetch);
  assign o_trap   = (r_state == StTrap);
`endif

endmodule

// File: rtl/mc_datapath.sv
// Multicycle RV32I-subset core: one ALU and one stall-tolerant memory port shared across states.
// Define MC_PERF_CNT_EN to add the CycleCnt/InstrRetCnt performance counters.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  mc_datapath_if.master    bus,
  output logic             Illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]  CycleCnt,
  output logic [XLEN-1:0]  InstrRetCnt
`endif
);

  logic [XLEN-1:0] r_pc, r_old_pc, r_a, r_b, r_alu_out, r_data;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_rf [32];

  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm, w_src_a, w_src_b, w_alu_result, w_result, w_pc_next;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_zero;

  assign w_rs1 = r_instr[19:15];
  assign w_rs2 = r_instr[24:20];
  assign w_rd  = r_instr[11:7];

  mc_controller u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .i_op        (r_instr[6:0]),
    .i_funct3    (r_instr[14:12]),
    .i_funct7b5  (r_instr[30]),
    .i_zero      (w_zero),
    .i_mem_ready (bus.MemReady),
    .o_ctrl      (w_ctrl),
    .o_illegal   (Illegal)
`ifdef MC_PERF_CNT_EN
    ,
    .o_retire    (w_retire),
    .o_trap      (w_trap)
`endif
  );

  assign bus.MemReq   = w_ctrl.mem_req;
  assign bus.MemWE    = w_ctrl.mem_we;
  assign bus.MemAdr   = w_ctrl.adr_src ? r_alu_out : r_pc;
  assign bus.MemWData = r_b;

  // x0 is never written, but reads are forced to zero regardless of array contents.
  always_ff @(posedge clk) begin
    if (w_ctrl.reg_we && (w_rd != 5'd0)) r_rf[w_rd] <= w_result;
  end
  assign w_rs1_data = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];

  always_comb begin
    case (w_ctrl.imm_src)
      ImmI:    w_imm = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
      ImmS:    w_imm = {{(XLEN-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      ImmB:    w_imm = {{(XLEN-12){r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8],
                        1'b0};
      default: w_imm = {{(XLEN-20){r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21],
                        1'b0};
    endcase
  end

  always_comb begin
    case (w_ctrl.src_a)
      SrcAPc:    w_src_a = r_pc;
      SrcAOldPc: w_src_a = r_old_pc;
      default:   w_src_a = r_a;
    endcase
    case (w_ctrl.src_b)
      SrcBRegB: w_src_b = r_b;
      SrcBImm:  w_src_b = w_imm;
      default:  w_src_b = XLEN'(4);
    endcase
  end

  always_comb begin
    case (w_ctrl.alu_ctrl)
      AluAdd:  w_alu_result = w_src_a + w_src_b;
      AluSub:  w_alu_result = w_src_a - w_src_b;
      AluAnd:  w_alu_result = w_src_a & w_src_b;
      AluOr:   w_alu_result = w_src_a | w_src_b;
      AluSlt:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
      default: w_alu_result = w_src_a + w_src_b;
    endcase
  end
  assign w_zero = (w_alu_result == '0);

  assign w_pc_next = w_ctrl.pc_src ? r_alu_out : w_alu_result;

  always_comb begin
    case (w_ctrl.result_src)
      ResAluOut: w_result = r_alu_out;
      ResData:   w_result = r_data;
      default:   w_result = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_ctrl.pc_we) begin
      r_pc <= w_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ctrl.ir_we) begin
      r_instr  <= bus.MemRData;
      r_old_pc <= r_pc;
    end
    if (w_ctrl.ab_we) begin
      r_a <= w_rs1_data;
      r_b <= w_rs2_data;
    end
    if (w_ctrl.aluout_we) r_alu_out <= w_alu_result;
    if (w_ctrl.data_we)   r_data    <= bus.MemRData;
  end

`ifdef MC_PERF_CNT_EN
  logic            w_retire, w_trap;
  logic [XLEN-1:0] r_cycle_cnt, r_instret_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else if (!w_trap) begin
      r_cycle_cnt <= r_cycle_cnt + XLEN'(1);
      if (w_retire) r_instret_cnt <= r_instret_cnt + XLEN'(1);
    end
  end

  assign CycleCnt    = r_cycle_cnt;
  assign InstrRetCnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: the bench plays the memory and checks every bus access
// (address, direction, store data, spacing and stall stability) against a hand-built trace.
module tb_mc_datapath;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    int          idle;
  } acc_t;

  logic clk = 1'b0;
  logic reset;
  logic illegal;
  int   n_tests = 0;
  int   n_fail  = 0;

  mc_datapath_if #(.XLEN(32)) bus ();

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc, ret;
  logic [31:0] cyc_snap;
`endif

  mc_datapath #(
    .XLEN     (32),
    .RESET_PC (32'h100)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .Illegal (illegal)
`ifdef MC_PERF_CNT_EN
    ,
    .CycleCnt    (cyc),
    .InstrRetCnt (ret)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  function automatic acc_t fet(logic [31:0] pc, logic [31:0] instr, int idle, int stall);
    acc_t a;
    a.we = 1'b0; a.adr = pc; a.wdata = '0; a.rdata = instr; a.stall = stall; a.idle = idle;
    return a;
  endfunction

  function automatic acc_t st(logic [31:0] adr, logic [31:0] wdata, int idle);
    acc_t a;
    a.we = 1'b1; a.adr = adr; a.wdata = wdata; a.rdata = '0; a.stall = 0; a.idle = idle;
    return a;
  endfunction

  function automatic acc_t ld(logic [31:0] adr, logic [31:0] rdata, int idle, int stall);
    acc_t a;
    a.we = 1'b0; a.adr = adr; a.wdata = '0; a.rdata = rdata; a.stall = stall; a.idle = idle;
    return a;
  endfunction

  // Entered just after a clock edge; returns just after the completing edge.
  task automatic do_access(input acc_t a, input int idx);
    int idle = 0;
    bus.MemReady = 1'b0;
    @(negedge clk);
    while (!bus.MemReq && idle < 40) begin
      idle++;
      @(negedge clk);
    end
    if (!bus.MemReq) begin
      check($sformatf("req_timeout#%0d", idx), 32'(bus.MemReq), 32'd1);
      return;
    end
    check($sformatf("idle#%0d", idx), 32'(idle), 32'(a.idle));
    check($sformatf("we#%0d", idx), 32'(bus.MemWE), 32'(a.we));
    check($sformatf("adr#%0d", idx), bus.MemAdr, a.adr);
    if (a.we) check($sformatf("wdata#%0d", idx), bus.MemWData, a.wdata);
    for (int s = 0; s < a.stall; s++) begin
      @(negedge clk);
      check($sformatf("stall_req#%0d.%0d", idx, s), 32'(bus.MemReq), 32'd1);
      check($sformatf("stall_we#%0d.%0d", idx, s), 32'(bus.MemWE), 32'(a.we));
      check($sformatf("stall_adr#%0d.%0d", idx, s), bus.MemAdr, a.adr);
    end
    bus.MemRData = a.rdata;
    bus.MemReady = 1'b1;
    @(posedge clk);
    #1;
    bus.MemReady = 1'b0;
    bus.MemRData = 32'hDEAD_BEEF;
  endtask

  initial begin
    acc_t tbl[$];
    int   req_seen;
    int   w;

    tbl.push_back(fet(32'h100, 32'h00500093, 0, 0)); // addi x1,x0,5
    tbl.push_back(fet(32'h104, 32'h00700113, 3, 0)); // addi x2,x0,7
    tbl.push_back(fet(32'h108, 32'h002081B3, 3, 2)); // add x3,x1,x2 (stalled fetch)
    tbl.push_back(fet(32'h10C, 32'h00302423, 3, 0)); // sw x3,8(x0)
    tbl.push_back(st (32'h8,   32'd12,       2));
    tbl.push_back(fet(32'h110, 32'h00802203, 0, 0)); // lw x4,8(x0)
    tbl.push_back(ld (32'h8,   32'd12,       2, 3));
    tbl.push_back(fet(32'h114, 32'h00402623, 1, 0)); // sw x4,12(x0)
    tbl.push_back(st (32'hC,   32'd12,       2));
    tbl.push_back(fet(32'h118, 32'hF09FF06F, 0, 0)); // jal x0,-0xF8 -> 0x20
    tbl.push_back(fet(32'h20,  32'h00108863, 2, 0)); // beq x1,x1,+16 taken
    tbl.push_back(fet(32'h30,  32'h00208863, 2, 0)); // beq x1,x2,+16 not taken
    tbl.push_back(fet(32'h34,  32'h00C0006F, 2, 0)); // jal x0,+12 -> 0x40
    tbl.push_back(fet(32'h40,  32'hFF9FF2EF, 2, 0)); // jal x5,-8 -> 0x38
    tbl.push_back(fet(32'h38,  32'h00208033, 2, 0)); // add x0,x1,x2
    tbl.push_back(fet(32'h3C,  32'h1000036F, 3, 0)); // jal x6,+0x100 -> 0x13C
    tbl.push_back(fet(32'h13C, 32'h00502823, 2, 0)); // sw x5,16(x0)
    tbl.push_back(st (32'h10,  32'h44,       2));
    tbl.push_back(fet(32'h140, 32'h00002A23, 0, 0)); // sw x0,20(x0)
    tbl.push_back(st (32'h14,  32'h0,        2));
    tbl.push_back(fet(32'h144, 32'h402083B3, 0, 0)); // sub x7,x1,x2
    tbl.push_back(fet(32'h148, 32'h0003A413, 3, 0)); // slti x8,x7,0
    tbl.push_back(fet(32'h14C, 32'h00702C23, 3, 0)); // sw x7,24(x0)
    tbl.push_back(st (32'h18,  32'hFFFF_FFFE, 2));
    tbl.push_back(fet(32'h150, 32'h00802E23, 0, 0)); // sw x8,28(x0)
    tbl.push_back(st (32'h1C,  32'h1,        2));
    tbl.push_back(fet(32'h154, 32'h0020F4B3, 0, 0)); // and x9,x1,x2
    tbl.push_back(fet(32'h158, 32'h0074E533, 3, 0)); // or x10,x9,x7
    tbl.push_back(fet(32'h15C, 32'h02A02023, 3, 0)); // sw x10,32(x0)
    tbl.push_back(st (32'h20,  32'hFFFF_FFFF, 2));
    tbl.push_back(fet(32'h160, 32'h02602223, 0, 0)); // sw x6,36(x0)
    tbl.push_back(st (32'h24,  32'h40,       2));
    tbl.push_back(fet(32'h164, 32'h0000007F, 0, 0)); // unsupported opcode

    reset        = 1'b1;
    bus.MemReady = 1'b0;
    bus.MemRData = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req", 32'(bus.MemReq), 32'd0);
    check("reset_we", 32'(bus.MemWE), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
`ifdef MC_PERF_CNT_EN
    check("reset_cyc", cyc, 32'd0);
    check("reset_ret", ret, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      do_access(tbl[i], i);
`ifdef MC_PERF_CNT_EN
      if (i == 4) check("instret_after_prog", ret, 32'd4);
`endif
    end

    // Trap: sticky flag, no further requests, stray MemReady ignored.
    repeat (3) @(negedge clk);
    check("trap_illegal", 32'(illegal), 32'd1);
`ifdef MC_PERF_CNT_EN
    cyc_snap = cyc;
`endif
    bus.MemReady = 1'b1;
    req_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.MemReq) req_seen++;
    end
    check("trap_no_req", 32'(req_seen), 32'd0);
    check("trap_illegal_sticky", 32'(illegal), 32'd1);
`ifdef MC_PERF_CNT_EN
    check("trap_cyc_frozen", cyc, cyc_snap);
`endif
    bus.MemReady = 1'b0;

    // Reset out of trap, then abandon a load mid-wait with a second reset.
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst1_illegal_clr", 32'(illegal), 32'd0);
`ifdef MC_PERF_CNT_EN
    check("rst1_cyc", cyc, 32'd0);
    check("rst1_ret", ret, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    do_access(fet(32'h100, 32'h00802203, 0, 0), 100); // lw x4,8(x0)
    w = 0;
    @(negedge clk);
    while (!bus.MemReq && w < 10) begin
      w++;
      @(negedge clk);
    end
    check("abort_rd_idle", 32'(w), 32'd2);
    check("abort_rd_adr", bus.MemAdr, 32'h8);
    check("abort_rd_we", 32'(bus.MemWE), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_req_low", 32'(bus.MemReq), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    do_access(fet(32'h100, 32'h00500093, 0, 0), 101);
    do_access(fet(32'h104, 32'h00700113, 3, 0), 102);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
